// File: rtl/lv_mode_ctrl_pkg.sv
// Shared types and mode-vector bit positions for the LV operating-mode controller.
package lv_mode_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_NORMAL = 3'd1,
        ST_CFG    = 3'd2,
        ST_BIST   = 3'd3,
        ST_FSISO  = 3'd4
    } lv_mode_st_e;

    localparam int MODE_RST_BIT    = 0;
    localparam int MODE_NORMAL_BIT = 1;
    localparam int MODE_CFG_BIT    = 2;
    localparam int MODE_BIST_BIT   = 3;
    localparam int MODE_FSISO_BIT  = 4;
    localparam int MODE_ADC_LSB    = 5;

    // efuse_done sits directly above the variable-width ADC enable field
    function automatic int mode_efuse_bit(input int adc_num);
        return MODE_ADC_LSB + adc_num;
    endfunction

endpackage

// File: rtl/lv_mode_ctrl_if.sv
// Request/status bundle between the SPI register bank (master) and the mode controller (slave).
interface lv_mode_ctrl_if #(
    parameter int ADC_NUM = 2
);
    logic               efuse_load_done_i;
    logic               cfg_req_i;
    logic               cfg_exit_i;
    logic               bist_req_i;
    logic               bist_done_i;
    logic               bist_fail_i;
    logic               fsiso_req_i;
    logic               fsiso_clr_i;
    logic [ADC_NUM-1:0] adc_scan_en_i;
    logic [ADC_NUM+5:0] mode_o;
    logic               mode_chg_o;
    logic               efuse_tmo_o;
    logic               bist_fail_o;

    modport master (
        output efuse_load_done_i, cfg_req_i, cfg_exit_i, bist_req_i, bist_done_i,
               bist_fail_i, fsiso_req_i, fsiso_clr_i, adc_scan_en_i,
        input  mode_o, mode_chg_o, efuse_tmo_o, bist_fail_o
    );

    modport slave (
        input  efuse_load_done_i, cfg_req_i, cfg_exit_i, bist_req_i, bist_done_i,
               bist_fail_i, fsiso_req_i, fsiso_clr_i, adc_scan_en_i,
        output mode_o, mode_chg_o, efuse_tmo_o, bist_fail_o
    );

endinterface

// File: rtl/lv_mode_ctrl_adc_rr.sv
// Round-robin ADC channel scheduler: one-hot over enabled channels, ADC_SLOT_CYC cycles each.
// Latency: run/enables sampled at an edge show on adc_en after that edge; no backpressure.
module lv_adc_rr_sched #(
    parameter int ADC_NUM      = 2,
    parameter int ADC_SLOT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [ADC_NUM-1:0] adc_scan_en_i,
    output logic [ADC_NUM-1:0] adc_en
);
    localparam int IDX_W  = (ADC_NUM > 1) ? $clog2(ADC_NUM) : 1;
    localparam int SLOT_W = $clog2(ADC_SLOT_CYC + 1);

    logic [IDX_W-1:0]  cur_q;
    logic [IDX_W-1:0]  nxt_idx;
    logic [IDX_W-1:0]  low_idx;
    logic [SLOT_W-1:0] slot_q;
    logic              active_q;

    // Descending loops so the lowest index / nearest-above channel is the last write
    always_comb begin
        int j;
        low_idx = '0;
        nxt_idx = cur_q;
        j       = 0;
        for (int i = ADC_NUM - 1; i >= 0; i--) begin
            if (adc_scan_en_i[IDX_W'(i)]) low_idx = IDX_W'(i);
        end
        for (int k = ADC_NUM; k >= 1; k--) begin
            j = int'(cur_q) + k;
            if (j >= ADC_NUM) j = j - ADC_NUM;
            if (adc_scan_en_i[IDX_W'(j)]) nxt_idx = IDX_W'(j);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q    <= '0;
            slot_q   <= '0;
            active_q <= 1'b0;
        end else if (!run || (adc_scan_en_i == '0)) begin
            cur_q    <= '0;
            slot_q   <= '0;
            active_q <= 1'b0;
        end else if (!active_q) begin
            cur_q    <= low_idx;
            slot_q   <= '0;
            active_q <= 1'b1;
        end else if (!adc_scan_en_i[cur_q] || (slot_q == SLOT_W'(ADC_SLOT_CYC - 1))) begin
            cur_q  <= nxt_idx;
            slot_q <= '0;
        end else begin
            slot_q <= slot_q + SLOT_W'(1);
        end
    end

    assign adc_en = active_q ? (ADC_NUM'(1) << cur_q) : '0;

endmodule

// File: rtl/lv_mode_ctrl.sv
// LV mode controller: mode FSM, efuse/BIST watchdogs, sticky fault flags, mode vector.
// Latency: requests sampled at an edge are reflected on mode_o at that edge; no backpressure.
module lv_mode_ctrl
    import lv_mode_ctrl_pkg::*;
#(
    parameter int ADC_NUM      = 2,
    parameter int ADC_SLOT_CYC = 16,
    parameter int EFUSE_TMO    = 200,
    parameter int BIST_TMO     = 1024
) (
    input logic           clk,
    input logic           rst_n,
    lv_mode_ctrl_if.slave bus
);
    localparam int EF_W = $clog2(EFUSE_TMO + 1);
    localparam int BI_W = $clog2(BIST_TMO + 1);

    lv_mode_st_e        state_q;
    lv_mode_st_e        state_nxt;
    logic [EF_W-1:0]    efuse_cnt_q;
    logic [BI_W-1:0]    bist_cnt_q;
    logic               efuse_done_q;
    logic               efuse_tmo_q;
    logic               bist_fail_q;
    logic               mode_chg_q;
    logic               set_done;
    logic               set_tmo;
    logic               set_fail;
    logic               run;
    logic [ADC_NUM-1:0] adc_en;
    logic [ADC_NUM+5:0] mode;

    // Scheduler keys off the next state so the ADC enable lands with the state change
    assign run = (state_nxt == ST_NORMAL);

    lv_adc_rr_sched #(
        .ADC_NUM      (ADC_NUM),
        .ADC_SLOT_CYC (ADC_SLOT_CYC)
    ) u_adc_rr (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .adc_scan_en_i (bus.adc_scan_en_i),
        .adc_en        (adc_en)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RST;
            mode_chg_q   <= 1'b0;
            efuse_cnt_q  <= '0;
            bist_cnt_q   <= '0;
            efuse_done_q <= 1'b0;
            efuse_tmo_q  <= 1'b0;
            bist_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            mode_chg_q   <= (state_nxt != state_q);
            efuse_cnt_q  <= (state_q == ST_RST && state_nxt == ST_RST) ? efuse_cnt_q + EF_W'(1) : '0;
            bist_cnt_q   <= (state_q == ST_BIST && state_nxt == ST_BIST) ? bist_cnt_q + BI_W'(1) : '0;
            efuse_done_q <= efuse_done_q | set_done;
            efuse_tmo_q  <= efuse_tmo_q | set_tmo;
            bist_fail_q  <= bist_fail_q | set_fail;
        end
    end

    always_comb begin
        state_nxt = state_q;
        set_done  = 1'b0;
        set_tmo   = 1'b0;
        set_fail  = 1'b0;
        case (state_q)
            ST_RST: begin
                if (bus.efuse_load_done_i) begin
                    state_nxt = ST_NORMAL;
                    set_done  = 1'b1;
                end else if (efuse_cnt_q == EF_W'(EFUSE_TMO - 1)) begin
                    state_nxt = ST_NORMAL;
                    set_tmo   = 1'b1;
                end
            end
            ST_NORMAL: begin
                if (bus.fsiso_req_i)     state_nxt = ST_FSISO;
                else if (bus.cfg_req_i)  state_nxt = ST_CFG;
                else if (bus.bist_req_i) state_nxt = ST_BIST;
            end
            ST_CFG: begin
                if (bus.fsiso_req_i)     state_nxt = ST_FSISO;
                else if (bus.cfg_exit_i) state_nxt = ST_NORMAL;
            end
            ST_BIST: begin
                if (bus.fsiso_req_i) begin
                    state_nxt = ST_FSISO;
                end else if (bus.bist_done_i) begin
                    state_nxt = bus.bist_fail_i ? ST_FSISO : ST_NORMAL;
                    set_fail  = bus.bist_fail_i;
                end else if (bist_cnt_q == BI_W'(BIST_TMO - 1)) begin
                    state_nxt = ST_FSISO;
                    set_fail  = 1'b1;
                end
            end
            ST_FSISO: begin
                if (bus.fsiso_clr_i && !bus.fsiso_req_i) state_nxt = ST_NORMAL;
            end
            default: state_nxt = ST_RST;
        endcase
    end

    always_comb begin
        mode                               = '0;
        mode[MODE_RST_BIT]                 = (state_q == ST_RST);
        mode[MODE_NORMAL_BIT]              = (state_q == ST_NORMAL);
        mode[MODE_CFG_BIT]                 = (state_q == ST_CFG);
        mode[MODE_BIST_BIT]                = (state_q == ST_BIST);
        mode[MODE_FSISO_BIT]               = (state_q == ST_FSISO);
        mode[MODE_ADC_LSB +: ADC_NUM]      = adc_en;
        mode[mode_efuse_bit(ADC_NUM)]      = efuse_done_q;
    end

    assign bus.mode_o      = mode;
    assign bus.mode_chg_o  = mode_chg_q;
    assign bus.efuse_tmo_o = efuse_tmo_q;
    assign bus.bist_fail_o = bist_fail_q;

endmodule

// File: tb/tb_lv_mode_ctrl.sv
// Directed bench for lv_mode_ctrl with ADC_NUM=4, slot 16, efuse timeout 200, BIST timeout 1024.
// mode_o bits: 0 rst, 1 normal, 2 cfg, 3 bist, 4 fsiso, 8:5 adc_en, 9 efuse_done.
module tb_lv_mode_ctrl;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    lv_mode_ctrl_if #(.ADC_NUM(4)) bus ();

    lv_mode_ctrl #(
        .ADC_NUM      (4),
        .ADC_SLOT_CYC (16),
        .EFUSE_TMO    (200),
        .BIST_TMO     (1024)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests                 = 0;
        failed                = 0;
        rst_n                 = 1'b0;
        bus.efuse_load_done_i = 1'b0;
        bus.cfg_req_i         = 1'b0;
        bus.cfg_exit_i        = 1'b0;
        bus.bist_req_i        = 1'b0;
        bus.bist_done_i       = 1'b0;
        bus.bist_fail_i       = 1'b0;
        bus.fsiso_req_i       = 1'b0;
        bus.fsiso_clr_i       = 1'b0;
        bus.adc_scan_en_i     = 4'b1011;

        // Reset values
        step(3);
        chk("rst_mode", 16'(bus.mode_o), 16'h001);
        chk("rst_chg", 16'(bus.mode_chg_o), 16'h0);
        chk("rst_tmo", 16'(bus.efuse_tmo_o), 16'h0);
        chk("rst_bfail", 16'(bus.bist_fail_o), 16'h0);

        // T1: efuse done at cycle 5
        rst_n = 1'b1;
        step(4);
        chk("t1_still_rst", 16'(bus.mode_o), 16'h001);
        bus.efuse_load_done_i = 1'b1;
        step(1);
        chk("t1_normal", 16'(bus.mode_o), 16'h222);
        chk("t1_chg", 16'(bus.mode_chg_o), 16'h1);
        step(1);
        bus.efuse_load_done_i = 1'b0;
        chk("t1_chg_once", 16'(bus.mode_chg_o), 16'h0);

        // T3: round robin over 1011, 16 cycles per slot
        step(14);
        chk("t3_ch0_end", 16'(bus.mode_o), 16'h222);
        step(1);
        chk("t3_ch1", 16'(bus.mode_o), 16'h242);
        step(15);
        chk("t3_ch1_end", 16'(bus.mode_o), 16'h242);
        step(1);
        chk("t3_ch3", 16'(bus.mode_o), 16'h302);
        step(15);
        chk("t3_ch3_end", 16'(bus.mode_o), 16'h302);
        step(1);
        chk("t3_wrap_ch0", 16'(bus.mode_o), 16'h222);
        step(16);
        chk("t3_ch1_again", 16'(bus.mode_o), 16'h242);
        step(3);
        bus.adc_scan_en_i = 4'b1001;
        step(1);
        chk("t3_skip_ch1", 16'(bus.mode_o), 16'h302);
        step(15);
        chk("t3_ch3_restart", 16'(bus.mode_o), 16'h302);
        step(1);
        chk("t3_ch0_after", 16'(bus.mode_o), 16'h222);
        step(15);
        chk("t3_ch0_hold", 16'(bus.mode_o), 16'h222);
        step(1);
        chk("t3_ch0_to_ch3", 16'(bus.mode_o), 16'h302);
        bus.adc_scan_en_i = 4'b1011;

        // T4: cfg beats bist; bist ignored in cfg; exit restarts at lowest channel
        bus.cfg_req_i  = 1'b1;
        bus.bist_req_i = 1'b1;
        step(1);
        bus.cfg_req_i  = 1'b0;
        chk("t4_cfg", 16'(bus.mode_o), 16'h204);
        chk("t4_chg", 16'(bus.mode_chg_o), 16'h1);
        step(1);
        bus.bist_req_i = 1'b0;
        chk("t4_cfg_hold", 16'(bus.mode_o), 16'h204);
        bus.cfg_exit_i = 1'b1;
        step(1);
        bus.cfg_exit_i = 1'b0;
        chk("t4_exit", 16'(bus.mode_o), 16'h222);

        // T5: BIST fail -> FSISO; clear gated by fsiso_req
        bus.bist_req_i = 1'b1;
        step(1);
        bus.bist_req_i = 1'b0;
        chk("t5_bist", 16'(bus.mode_o), 16'h208);
        step(3);
        bus.bist_done_i = 1'b1;
        bus.bist_fail_i = 1'b1;
        step(1);
        bus.bist_done_i = 1'b0;
        bus.bist_fail_i = 1'b0;
        chk("t5_fsiso", 16'(bus.mode_o), 16'h210);
        chk("t5_bfail", 16'(bus.bist_fail_o), 16'h1);
        bus.fsiso_req_i = 1'b1;
        bus.fsiso_clr_i = 1'b1;
        step(1);
        bus.fsiso_clr_i = 1'b0;
        chk("t5_clr_blocked", 16'(bus.mode_o), 16'h210);
        bus.fsiso_req_i = 1'b0;
        bus.fsiso_clr_i = 1'b1;
        step(1);
        bus.fsiso_clr_i = 1'b0;
        chk("t5_released", 16'(bus.mode_o), 16'h222);
        chk("t5_bfail_sticky", 16'(bus.bist_fail_o), 16'h1);
        bus.fsiso_req_i = 1'b1;
        bus.cfg_req_i   = 1'b1;
        step(1);
        bus.fsiso_req_i = 1'b0;
        bus.cfg_req_i   = 1'b0;
        chk("t5_fsiso_prio", 16'(bus.mode_o), 16'h210);
        bus.fsiso_clr_i = 1'b1;
        step(1);
        bus.fsiso_clr_i = 1'b0;
        chk("t5_back_normal", 16'(bus.mode_o), 16'h222);

        // T6: BIST watchdog, then async reset
        bus.bist_req_i = 1'b1;
        step(1);
        bus.bist_req_i = 1'b0;
        chk("t6_bist", 16'(bus.mode_o), 16'h208);
        step(1023);
        chk("t6_bist_last", 16'(bus.mode_o), 16'h208);
        step(1);
        chk("t6_tmo_fsiso", 16'(bus.mode_o), 16'h210);
        chk("t6_tmo_chg", 16'(bus.mode_chg_o), 16'h1);
        rst_n = 1'b0;
        #2;
        chk("t6_arst_mode", 16'(bus.mode_o), 16'h001);
        chk("t6_arst_bfail", 16'(bus.bist_fail_o), 16'h0);
        chk("t6_arst_chg", 16'(bus.mode_chg_o), 16'h0);

        // T2: efuse watchdog; fsiso_req ignored in ST_RST
        step(1);
        rst_n           = 1'b1;
        bus.fsiso_req_i = 1'b1;
        step(10);
        chk("t2_fsiso_ignored", 16'(bus.mode_o), 16'h001);
        bus.fsiso_req_i = 1'b0;
        step(189);
        chk("t2_rst_last", 16'(bus.mode_o), 16'h001);
        step(1);
        chk("t2_tmo_normal", 16'(bus.mode_o), 16'h022);
        chk("t2_tmo_flag", 16'(bus.efuse_tmo_o), 16'h1);
        chk("t2_tmo_chg", 16'(bus.mode_chg_o), 16'h1);
        bus.adc_scan_en_i = 4'b0000;
        step(1);
        chk("scan_off", 16'(bus.mode_o), 16'h002);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
